// File: rtl/pirisc_pkg.sv
// Shared piRISC definitions: fetch FSM states and fetch-stage constants.
package pirisc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int unsigned PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem read, one-entry buffer to decode,
// redirect from PC_controller takes priority over everything else.
module instr_fetch
  import pirisc_pkg::*;
#(
  parameter int unsigned        DWIDTH   = 32,
  parameter logic [DWIDTH-1:0]  RESET_PC = DWIDTH'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [DWIDTH-1:0] inst_pc
);

  fetch_state_t      state_r, state_s;
  logic [DWIDTH-1:0] fetch_pc_r, fetch_pc_s;
  logic              drop_r, drop_s;
  logic [31:0]       inst_data_r, inst_data_s;
  logic [DWIDTH-1:0] inst_pc_r, inst_pc_s;
  // Goes high on the first edge after reset release; keeps the request port
  // quiet while rst_n is low even though state already reads FETCH.
  logic              run_r;
  logic              req_fire_s;
  logic [DWIDTH-1:0] redirect_aligned_s;

  // Outputs are decoded from registered state only.
  assign imem_req_valid = run_r && (state_r == FETCH);
  assign imem_req_addr  = fetch_pc_r;
  assign inst_valid     = run_r && (state_r == FULL);
  assign inst_data      = inst_data_r;
  assign inst_pc        = inst_pc_r;

  assign req_fire_s         = imem_req_valid && imem_req_ready;
  // Word-align the redirect target by masking the two low bits.
  assign redirect_aligned_s = redirect_pc & ~(DWIDTH'(32'd3));

  // Next-state and datapath decode for the fetch FSM.
  always_comb begin
    state_s     = state_r;
    fetch_pc_s  = fetch_pc_r;
    drop_s      = drop_r;
    inst_data_s = inst_data_r;
    inst_pc_s   = inst_pc_r;
    case (state_r)
      FETCH: begin
        if (redirect_valid) begin
          fetch_pc_s = redirect_aligned_s;
          if (req_fire_s) begin
            // Old-address request already accepted: its response must be discarded.
            state_s = WAIT;
            drop_s  = 1'b1;
          end else begin
            state_s = FETCH;
          end
        end else if (req_fire_s) begin
          state_s = WAIT;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_s = redirect_aligned_s;
          if (imem_rsp_valid) begin
            // Response for the stale address arrives now; nothing left to drop.
            state_s = FETCH;
            drop_s  = 1'b0;
          end else begin
            drop_s  = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop_r) begin
            drop_s  = 1'b0;
            state_s = FETCH;
          end else begin
            inst_data_s = imem_rsp_data;
            inst_pc_s   = fetch_pc_r;
            fetch_pc_s  = fetch_pc_r + DWIDTH'(PC_STEP);
            state_s     = FULL;
          end
        end else begin
          state_s = WAIT;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          // Squash the buffered instruction and refetch from the target.
          fetch_pc_s = redirect_aligned_s;
          state_s    = FETCH;
        end else if (inst_ready) begin
          state_s = FETCH;
        end else begin
          state_s = FULL;
        end
      end
      default: begin
        state_s = FETCH;
        drop_s  = 1'b0;
      end
    endcase
  end

  // FSM state and datapath registers with async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r       <= 1'b0;
      state_r     <= FETCH;
      fetch_pc_r  <= RESET_PC;
      drop_r      <= 1'b0;
      inst_data_r <= NOP_INST;
      inst_pc_r   <= RESET_PC;
    end else begin
      run_r       <= 1'b1;
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      drop_r      <= drop_s;
      inst_data_r <= inst_data_s;
      inst_pc_r   <= inst_pc_s;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch (default and wrap-around RESET_PC).
module tb_instr_fetch;
  import pirisc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: default RESET_PC = 0
  logic        a_rst_n = 1'b0, a_redir_valid = 1'b0, a_req_ready = 1'b0;
  logic        a_rsp_valid = 1'b0, a_inst_ready = 1'b0;
  logic [31:0] a_redir_pc = 32'h0, a_rsp_data = 32'h0;
  logic        a_req_valid, a_inst_valid;
  logic [31:0] a_req_addr, a_inst_data, a_inst_pc;

  instr_fetch dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .redirect_valid(a_redir_valid), .redirect_pc(a_redir_pc),
    .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_req_addr(a_req_addr),
    .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
    .inst_valid(a_inst_valid), .inst_ready(a_inst_ready),
    .inst_data(a_inst_data), .inst_pc(a_inst_pc)
  );

  // Instance B: RESET_PC at the top of the address space
  logic        b_rst_n = 1'b0, b_redir_valid = 1'b0, b_req_ready = 1'b0;
  logic        b_rsp_valid = 1'b0, b_inst_ready = 1'b0;
  logic [31:0] b_redir_pc = 32'h0, b_rsp_data = 32'h0;
  logic        b_req_valid, b_inst_valid;
  logic [31:0] b_req_addr, b_inst_data, b_inst_pc;

  instr_fetch #(.DWIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .redirect_valid(b_redir_valid), .redirect_pc(b_redir_pc),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .inst_valid(b_inst_valid), .inst_ready(b_inst_ready),
    .inst_data(b_inst_data), .inst_pc(b_inst_pc)
  );

  // Memory contents as seen by the bench: a tagged copy of the address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From FETCH with request at address a: accept, respond next cycle, land in FULL.
  task automatic issue_to_full(input logic [31:0] a);
    chk("req_valid", {31'd0, a_req_valid}, 32'd1);
    chk("req_addr", a_req_addr, a);
    a_req_ready = 1'b1;
    tick();
    a_req_ready = 1'b0;
    chk("wait_no_req", {31'd0, a_req_valid}, 32'd0);
    chk("wait_no_inst", {31'd0, a_inst_valid}, 32'd0);
    a_rsp_valid = 1'b1;
    a_rsp_data  = mw(a);
    tick();
    a_rsp_valid = 1'b0;
    chk("full_valid", {31'd0, a_inst_valid}, 32'd1);
    chk("full_pc", a_inst_pc, a);
    chk("full_data", a_inst_data, mw(a));
  endtask

  // Full fetch cycle with decode stalling 'hold' cycles before accepting.
  task automatic fetch_one(input logic [31:0] a, input int hold);
    issue_to_full(a);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", {31'd0, a_inst_valid}, 32'd1);
      chk("hold_pc", a_inst_pc, a);
      chk("hold_data", a_inst_data, mw(a));
      chk("hold_no_req", {31'd0, a_req_valid}, 32'd0);
    end
    a_inst_ready = 1'b1;
    tick();
    a_inst_ready = 1'b0;
    chk("accepted_empty", {31'd0, a_inst_valid}, 32'd0);
  endtask

  initial begin
    // ---------------- Instance A ----------------
    a_req_ready = 1'b1;
    tick();
    chk("rst_req_valid", {31'd0, a_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, a_inst_valid}, 32'd0);
    chk("rst_inst_data", a_inst_data, 32'h0000_0013);
    chk("rst_inst_pc", a_inst_pc, 32'h0000_0000);
    a_req_ready = 1'b0;
    a_rst_n = 1'b1;
    tick();

    fetch_one(32'h0000_0000, 0);
    fetch_one(32'h0000_0004, 5);
    issue_to_full(32'h0000_0008);

    // Redirect while FULL with decode stalled
    a_redir_valid = 1'b1;
    a_redir_pc    = 32'h0000_0040;
    tick();
    a_redir_valid = 1'b0;
    chk("full_redir_squash", {31'd0, a_inst_valid}, 32'd0);
    chk("full_redir_req", {31'd0, a_req_valid}, 32'd1);
    chk("full_redir_addr", a_req_addr, 32'h0000_0040);

    // Redirect while WAIT, response three cycles later is dropped
    a_req_ready = 1'b1;
    tick();
    a_req_ready = 1'b0;
    a_redir_valid = 1'b1;
    a_redir_pc    = 32'h0000_0100;
    tick();
    a_redir_valid = 1'b0;
    chk("wait_redir_no_req", {31'd0, a_req_valid}, 32'd0);
    tick();
    tick();
    a_rsp_valid = 1'b1;
    a_rsp_data  = mw(32'h0000_0040);
    tick();
    a_rsp_valid = 1'b0;
    chk("drop_no_inst", {31'd0, a_inst_valid}, 32'd0);
    fetch_one(32'h0000_0100, 0);

    // Redirect in FETCH without ready: new address next cycle
    a_redir_valid = 1'b1;
    a_redir_pc    = 32'h0000_0010;
    tick();
    chk("fetch_redir_addr", a_req_addr, 32'h0000_0010);
    chk("fetch_redir_valid", {31'd0, a_req_valid}, 32'd1);
    // Redirect to unaligned target in same cycle as acceptance of 0x10
    a_redir_pc  = 32'h0000_0203;
    a_req_ready = 1'b1;
    tick();
    a_redir_valid = 1'b0;
    a_req_ready   = 1'b0;
    chk("accept_redir_wait", {31'd0, a_req_valid}, 32'd0);
    a_rsp_valid = 1'b1;
    a_rsp_data  = mw(32'h0000_0010);
    tick();
    a_rsp_valid = 1'b0;
    chk("accept_redir_drop", {31'd0, a_inst_valid}, 32'd0);
    fetch_one(32'h0000_0200, 0);

    // Redirect coinciding with the response in WAIT: discarded, drop stays clear
    a_req_ready = 1'b1;
    tick();
    a_req_ready   = 1'b0;
    a_redir_valid = 1'b1;
    a_redir_pc    = 32'h0000_0300;
    a_rsp_valid   = 1'b1;
    a_rsp_data    = mw(32'h0000_0204);
    tick();
    a_redir_valid = 1'b0;
    a_rsp_valid   = 1'b0;
    chk("coinc_no_inst", {31'd0, a_inst_valid}, 32'd0);
    fetch_one(32'h0000_0300, 0);

    // ---------------- Instance B ----------------
    tick();
    b_rst_n = 1'b1;
    tick();
    chk("b_first_valid", {31'd0, b_req_valid}, 32'd1);
    chk("b_first_addr", b_req_addr, 32'hFFFF_FFFC);
    b_req_ready = 1'b1;
    tick();
    b_req_ready = 1'b0;
    b_rsp_valid = 1'b1;
    b_rsp_data  = 32'hDEAD_BEEF;
    tick();
    b_rsp_valid = 1'b0;
    chk("b_full_pc", b_inst_pc, 32'hFFFF_FFFC);
    chk("b_full_data", b_inst_data, 32'hDEAD_BEEF);
    b_inst_ready = 1'b1;
    tick();
    b_inst_ready = 1'b0;
    chk("b_wrap_addr", b_req_addr, 32'h0000_0000);
    chk("b_wrap_valid", {31'd0, b_req_valid}, 32'd1);
    b_req_ready = 1'b1;
    tick();
    b_req_ready = 1'b0;
    #3;
    b_rst_n = 1'b0;
    #1;
    chk("b_midwait_req", {31'd0, b_req_valid}, 32'd0);
    chk("b_midwait_inst", {31'd0, b_inst_valid}, 32'd0);
    chk("b_midwait_pc", b_inst_pc, 32'hFFFF_FFFC);
    chk("b_midwait_data", b_inst_data, 32'h0000_0013);
    tick();
    b_rst_n = 1'b1;
    tick();
    chk("b_restart_valid", {31'd0, b_req_valid}, 32'd1);
    chk("b_restart_addr", b_req_addr, 32'hFFFF_FFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
